lsu_ctrl: RTL and testbench

Load/store controller between the EX/MEM pipeline register and the `mem` data-memory block. Accepts one load or store per valid/ready handshake and checks alignment and range. Drives word-only memory accesses, using read-modify-write for byte and halfword stores. Returns extended load data with a fault flag on a valid/ready response channel to the writeback stage.

---
 rtl/lsu_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store controller between EX/MEM and the word-wide data memory.
// Optional feature macro: LSU_SUBWORD_EN (byte/half accesses and read-modify-write stores).
module lsu_ctrl #(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_fault_q, resp_fault_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        accept_s;
    logic        fault_s;
    logic [31:0] word_addr_s;

`ifdef LSU_SUBWORD_EN
    function automatic logic [31:0] extract_lane(input logic [31:0] word, input logic [1:0] off,
                                                 input logic [1:0] size, input logic sext);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   res = {{24{sext & b[7]}}, b};
            2'b01:   res = {{16{sext & h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // The held old word with only the addressed lane replaced by store data.
    function automatic logic [31:0] merge_lane(input logic [31:0] old, input logic [1:0] off,
                                               input logic [1:0] size, input logic [31:0] data);
        logic [31:0] res;
        res = old;
        case (size)
            2'b00: res[{off, 3'b000} +: 8] = data[7:0];
            2'b01: begin
                if (off[1]) begin
                    res[31:16] = data[15:0];
                end else begin
                    res[15:0] = data[15:0];
                end
            end
            default: res = data;
        endcase
        return res;
    endfunction
`else
    logic unused_s;
    assign unused_s = ^{write_q, size_q, signed_q, addr_q, wdata_q};
`endif

    assign accept_s    = req_valid && req_ready;
    assign word_addr_s = {req_addr[31:2], 2'b00};

    // Classify the incoming request: reserved size, misalignment or out of range.
    always_comb begin
        fault_s = 1'b0;
        case (req_size)
`ifdef LSU_SUBWORD_EN
            2'b00:   fault_s = 1'b0;
            2'b01:   fault_s = req_addr[0];
`else
            2'b00,
            2'b01:   fault_s = 1'b1;
`endif
            2'b10:   fault_s = (req_addr[1:0] != 2'b00);
            default: fault_s = 1'b1;
        endcase
        if (req_addr >= ADDR_LIMIT) begin
            fault_s = 1'b1;
        end else begin
            fault_s = fault_s;
        end
    end

    // Next-state and next-output computation; memory strobes are registered one state ahead.
    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        size_d       = size_q;
        signed_d     = signed_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_fault_d = resp_fault_q;
        mem_rd_d     = 1'b0;
        mem_wr_d     = 1'b0;
        mem_addr_d   = 32'h0000_0000;
        mem_wdata_d  = 32'h0000_0000;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    write_d  = req_write;
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    if (fault_s) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = 32'h0000_0000;
                        resp_fault_d = 1'b1;
                    end else if (req_write && (req_size == 2'b10)) begin
                        state_d     = WRITE;
                        mem_wr_d    = 1'b1;
                        mem_addr_d  = word_addr_s;
                        mem_wdata_d = req_wdata;
                    end else begin
                        state_d    = READ;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = word_addr_s;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
`ifdef LSU_SUBWORD_EN
                if (write_q) begin
                    state_d     = WRITE;
                    mem_wr_d    = 1'b1;
                    mem_addr_d  = mem_addr_q;
                    mem_wdata_d = merge_lane(mem_rdata, addr_q[1:0], size_q, wdata_q);
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = extract_lane(mem_rdata, addr_q[1:0], size_q, signed_q);
                    resp_fault_d = 1'b0;
                end
`else
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = mem_rdata;
                resp_fault_d = 1'b0;
`endif
            end
            WRITE: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = 32'h0000_0000;
                resp_fault_d = 1'b0;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    resp_rdata_d = 32'h0000_0000;
                    resp_fault_d = 1'b0;
                end else begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, captured request and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            addr_q       <= 32'h0000_0000;
            wdata_q      <= 32'h0000_0000;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
            resp_fault_q <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= 32'h0000_0000;
            mem_wdata_q  <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_fault_q <= resp_fault_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready  = (state_q == IDLE) && !rst;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_fault = resp_fault_q;
    assign mem_rd     = mem_rd_q;
    // Gate with reset so a reset arriving mid-WRITE kills the strobe at once.
    assign mem_wr     = mem_wr_q && !rst;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl with a word-wide memory model.
// Expectations follow LSU_SUBWORD_EN the same way the design does.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_rdata;

    logic [31:0] mem_model [0:1023];
    int          rd_total = 0;
    int          wr_total = 0;
    int          checks = 0;
    int          failures = 0;

    lsu_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_fault(resp_fault),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem_model[mem_addr[11:2]];

    always @(posedge clk) begin
        if (mem_wr) mem_model[mem_addr[11:2]] <= mem_wdata;
        if (mem_rd) rd_total <= rd_total + 1;
        if (mem_wr) wr_total <= wr_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One request/response transaction; lat counts edges from acceptance to resp_valid.
    task automatic xact(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic flt);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd  = resp_rdata;
        flt = resp_fault;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic run_ok(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int exp_lat, input logic [31:0] exp_rd);
        int lat; logic [31:0] rd; logic flt;
        xact(w, sz, sg, a, wd, lat, rd, flt);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_fault"}, {31'd0, flt}, 32'd0);
    endtask

    task automatic run_fault(input string tag, input logic w, input logic [1:0] sz,
                             input logic [31:0] a);
        int lat; logic [31:0] rd; logic flt; int r0; int w0;
        r0 = rd_total; w0 = wr_total;
        xact(w, sz, 1'b1, a, 32'hFFFF_FFFF, lat, rd, flt);
        check({tag, "_lat"}, lat, 32'd1);
        check({tag, "_rdata"}, rd, 32'd0);
        check({tag, "_fault"}, {31'd0, flt}, 32'd1);
        check({tag, "_memops"}, (rd_total - r0) + (wr_total - w0), 32'd0);
    endtask

    initial begin
        int r0; int w0; int cyc;
        logic [31:0] held;
        logic [31:0] w10;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_resp", {resp_valid, resp_fault, mem_rd, mem_wr}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk); rst = 1'b0;
        #1;
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);

        // Word store then word load
        r0 = rd_total; w0 = wr_total;
        run_ok("st_w", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 2, 32'd0);
        check("st_w_mem", mem_model[4], 32'hDEAD_BEEF);
        check("st_w_ops", {rd_total - r0, wr_total - w0}, {32'd0, 32'd1});
        r0 = rd_total;
        run_ok("ld_w", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 32'hDEAD_BEEF);
        check("ld_w_rd", rd_total - r0, 32'd1);
        w10 = 32'hDEAD_BEEF;

`ifdef LSU_SUBWORD_EN
        run_ok("st_w2", 1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, 2, 32'd0);
        r0 = rd_total; w0 = wr_total;
        run_ok("st_b", 1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_00A5, 3, 32'd0);
        check("st_b_mem", mem_model[4], 32'hA522_3344);
        check("st_b_ops", {rd_total - r0, wr_total - w0}, {32'd1, 32'd1});
        run_ok("ld_bs", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 2, 32'hFFFF_FFA5);
        run_ok("ld_bu", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 2, 32'h0000_00A5);
        run_ok("ld_b1", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 2, 32'h0000_0033);
        run_ok("st_h", 1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_8001, 3, 32'd0);
        run_ok("st_h0", 1'b1, 2'b01, 1'b0, 32'h10, 32'hFFFF_7FFF, 3, 32'd0);
        check("st_h_mem", mem_model[4], 32'h8001_7FFF);
        run_ok("ld_hs_hi", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 2, 32'hFFFF_8001);
        run_ok("ld_hs_lo", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 2, 32'h0000_7FFF);
        run_ok("ld_hu_hi", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 2, 32'h0000_8001);
        run_fault("f_half_mis", 1'b1, 2'b01, 32'h11);
        w10 = 32'h8001_7FFF;
`else
        run_fault("f_byte_dis", 1'b0, 2'b00, 32'h13);
        run_fault("f_half_dis", 1'b0, 2'b01, 32'h10);
        run_fault("f_bst_dis", 1'b1, 2'b00, 32'h10);
        check("bst_dis_mem", mem_model[4], 32'hDEAD_BEEF);
`endif

        // Fault boundaries
        run_fault("f_word_mis", 1'b0, 2'b10, 32'h102);
        run_fault("f_size11", 1'b0, 2'b11, 32'h10);
        run_fault("f_range", 1'b0, 2'b10, 32'h1000);
        run_fault("f_range_st", 1'b1, 2'b10, 32'hFFFF_FFFC);
        run_ok("st_top", 1'b1, 2'b10, 1'b0, 32'hFFC, 32'h0BAD_CAFE, 2, 32'd0);
        run_ok("ld_top", 1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0, 2, 32'h0BAD_CAFE);

        // Backpressure with a competing request waiting
        run_ok("st_20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h0000_0000, 2, 32'd0);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h10;
        @(posedge clk); #1;
        req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h0000_0055;
        cyc = 0;
        while (!resp_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("bp_lat", cyc, 32'd1);
        w0 = wr_total;
        held = resp_rdata;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_valid", {resp_valid, resp_fault, req_ready}, {29'd0, 3'b100});
            check("bp_rdata", resp_rdata, w10);
        end
        check("bp_held", held, w10);
        check("bp_no_wr", wr_total - w0, 32'd0);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("bp_ready_after", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 0;
        while (!resp_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("bp_second_mem", mem_model[8], 32'h0000_0055);

        // Reset during WRITE suppresses the store
        run_ok("st_30", 1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFE_F00D, 2, 32'd0);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h30;
        req_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rw_mem_wr_on", {31'd0, mem_wr}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rw_mem_wr_off", {31'd0, mem_wr}, 32'd0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rw_no_resp", {31'd0, resp_valid}, 32'd0);
        check("rw_ready", {31'd0, req_ready}, 32'd1);
        check("rw_mem", mem_model[12], 32'hCAFE_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
